// File: rtl/ctrl_pkg.sv
// Shared definitions for the instruction-sequencer slice: FSM state encoding,
// opcode and ALU-operation constants, and the decoded instruction class.
package ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7,
        HALT = 4'd8
    } state_t;

    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_JAL  = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_INC = 5'b01111;

    // Exactly one field is set for any opcode.
    typedef struct packed {
        logic jr;
        logic jal;
        logic br;
        logic nop;
        logic halt;
        logic ill;
    } instr_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: ir[31:27] to a one-hot instruction class.
// Build option CTRL_SEQ_JAL_EN: when undefined, jal classifies as illegal.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [4:0]   opcode,
    output instr_class_t cls
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        cls = '0;
        case (opcode)
            OP_JR:   cls.jr   = 1'b1;
`ifdef CTRL_SEQ_JAL_EN
            OP_JAL:  cls.jal  = 1'b1;
`endif
            OP_BR:   cls.br   = 1'b1;
            OP_NOP:  cls.nop  = 1'b1;
            OP_HALT: cls.halt = 1'b1;
            default: cls.ill  = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Control-unit sequencer: fetch (T0-T2), execute (T3-T6), HALT, and a count of
// completed instructions. Build option CTRL_SEQ_JAL_EN enables the jal sequence.
module ctrl_sequencer
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic        Pout,
    output logic        MARen,
    output logic        ZLOen,
    output logic        ZLOout,
    output logic        Pen,
    output logic        Read,
    output logic        MDRen,
    output logic        MDROut,
    output logic        IRen,
    output logic        Gra,
    output logic        Rout,
    output logic        BAout,
    output logic        Yen,
    output logic        Yout,
    output logic        R15en,
    output logic        Cout,
    output logic        ConIn,
    output logic [4:0]  alu_control,
    output logic        run,
    output logic        illegal,
    output logic [15:0] instr_count
);

    state_t       state;
    state_t       state_nxt;
    instr_class_t cls;
    logic         jal_q;
    logic         t1_entry;
    logic         cnt_inc;
    logic [15:0]  count_q;

    // Only the opcode field matters to sequencing.
    logic unused_ir;
    assign unused_ir = ^ir[26:0];

    ctrl_decode u_decode (
        .opcode (ir[31:27]),
        .cls    (cls)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            jal_q    <= 1'b0;
            t1_entry <= 1'b0;
            count_q  <= '0;
        end else begin
            state    <= state_nxt;
            // High exactly on the first cycle spent in T1.
            t1_entry <= (state != T1);
            if (state == T3) begin
                jal_q <= cls.jal;
            end
            if (cnt_inc) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign instr_count = count_q;

    always_comb begin
        state_nxt   = state;
        Pout        = 1'b0;
        MARen       = 1'b0;
        ZLOen       = 1'b0;
        ZLOout      = 1'b0;
        Pen         = 1'b0;
        Read        = 1'b0;
        MDRen       = 1'b0;
        MDROut      = 1'b0;
        IRen        = 1'b0;
        Gra         = 1'b0;
        Rout        = 1'b0;
        BAout       = 1'b0;
        Yen         = 1'b0;
        Yout        = 1'b0;
        R15en       = 1'b0;
        Cout        = 1'b0;
        ConIn       = 1'b0;
        alu_control = 5'b0;
        run         = 1'b0;
        illegal     = 1'b0;
        cnt_inc     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = T0;
                end
            end
            T0: begin
                run         = 1'b1;
                Pout        = 1'b1;
                MARen       = 1'b1;
                ZLOen       = 1'b1;
                alu_control = ALU_INC;
                state_nxt   = T1;
            end
            T1: begin
                run    = 1'b1;
                Read   = 1'b1;
                MDRen  = 1'b1;
                // PC update happens once even if memory stalls.
                ZLOout = t1_entry;
                Pen    = t1_entry;
                if (mem_ready) begin
                    state_nxt = T2;
                end
            end
            T2: begin
                run       = 1'b1;
                MDROut    = 1'b1;
                IRen      = 1'b1;
                state_nxt = T3;
            end
            T3: begin
                run       = 1'b1;
                state_nxt = T0;
                if (cls.jr) begin
                    Gra     = 1'b1;
                    Rout    = 1'b1;
                    BAout   = 1'b1;
                    Pen     = 1'b1;
                    cnt_inc = 1'b1;
                end else if (cls.jal) begin
                    Gra       = 1'b1;
                    Rout      = 1'b1;
                    Yen       = 1'b1;
                    state_nxt = T4;
                end else if (cls.br) begin
                    Gra       = 1'b1;
                    Rout      = 1'b1;
                    ConIn     = 1'b1;
                    state_nxt = T4;
                end else if (cls.nop) begin
                    cnt_inc = 1'b1;
                end else if (cls.halt) begin
                    cnt_inc   = 1'b1;
                    state_nxt = HALT;
                end else if (cls.ill) begin
                    illegal = 1'b1;
                    cnt_inc = 1'b1;
                end
            end
            T4: begin
                run       = 1'b1;
                Pout      = 1'b1;
                state_nxt = T5;
                if (jal_q) begin
`ifdef CTRL_SEQ_JAL_EN
                    R15en = 1'b1;
`endif
                end else begin
                    Yen = 1'b1;
                end
            end
            T5: begin
                run = 1'b1;
                if (jal_q) begin
`ifdef CTRL_SEQ_JAL_EN
                    Yout = 1'b1;
`endif
                    Pen       = 1'b1;
                    cnt_inc   = 1'b1;
                    state_nxt = T0;
                end else begin
                    Cout        = 1'b1;
                    ZLOen       = 1'b1;
                    alu_control = ALU_ADD;
                    state_nxt   = T6;
                end
            end
            T6: begin
                run       = 1'b1;
                ZLOout    = 1'b1;
                Pen       = con_ff;
                cnt_inc   = 1'b1;
                state_nxt = T0;
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed and random instruction streams
// compared cycle by cycle against expected strobe sequences built per instruction.
module tb_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic        mem_ready;
    logic [31:0] ir;
    logic        con_ff;
    logic        Pout, MARen, ZLOen, ZLOout, Pen, Read, MDRen, MDROut, IRen;
    logic        Gra, Rout, BAout, Yen, Yout, R15en, Cout, ConIn;
    logic [4:0]  alu_control;
    logic        run;
    logic        illegal;
    logic [15:0] instr_count;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] model_count;

    localparam logic [4:0] C_BR   = 5'b10010;
    localparam logic [4:0] C_JR   = 5'b10011;
    localparam logic [4:0] C_JAL  = 5'b10100;
    localparam logic [4:0] C_NOP  = 5'b11001;
    localparam logic [4:0] C_HALT = 5'b11010;
    localparam logic [4:0] A_ADD  = 5'b00011;
    localparam logic [4:0] A_INC  = 5'b01111;

    localparam logic [16:0] S_POUT   = 17'h00001;
    localparam logic [16:0] S_MAREN  = 17'h00002;
    localparam logic [16:0] S_ZLOEN  = 17'h00004;
    localparam logic [16:0] S_ZLOOUT = 17'h00008;
    localparam logic [16:0] S_PEN    = 17'h00010;
    localparam logic [16:0] S_READ   = 17'h00020;
    localparam logic [16:0] S_MDREN  = 17'h00040;
    localparam logic [16:0] S_MDROUT = 17'h00080;
    localparam logic [16:0] S_IREN   = 17'h00100;
    localparam logic [16:0] S_GRA    = 17'h00200;
    localparam logic [16:0] S_ROUT   = 17'h00400;
    localparam logic [16:0] S_BAOUT  = 17'h00800;
    localparam logic [16:0] S_YEN    = 17'h01000;
    localparam logic [16:0] S_YOUT   = 17'h02000;
    localparam logic [16:0] S_R15EN  = 17'h04000;
    localparam logic [16:0] S_COUT   = 17'h08000;
    localparam logic [16:0] S_CONIN  = 17'h10000;

    typedef enum {K_JR, K_JAL, K_BR, K_NOP, K_HALT, K_ILL} kind_t;

    ctrl_sequencer dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .mem_ready   (mem_ready),
        .ir          (ir),
        .con_ff      (con_ff),
        .Pout        (Pout),
        .MARen       (MARen),
        .ZLOen       (ZLOen),
        .ZLOout      (ZLOout),
        .Pen         (Pen),
        .Read        (Read),
        .MDRen       (MDRen),
        .MDROut      (MDROut),
        .IRen        (IRen),
        .Gra         (Gra),
        .Rout        (Rout),
        .BAout       (BAout),
        .Yen         (Yen),
        .Yout        (Yout),
        .R15en       (R15en),
        .Cout        (Cout),
        .ConIn       (ConIn),
        .alu_control (alu_control),
        .run         (run),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] ow(input logic [16:0] s, input logic [4:0] alu,
                                       input logic r, input logic ill);
        return {ill, r, alu, s};
    endfunction

    function automatic logic [23:0] observed();
        return {illegal, run, alu_control, ConIn, Cout, R15en, Yout, Yen, BAout, Rout,
                Gra, IRen, MDROut, MDRen, Read, Pen, ZLOout, ZLOen, MARen, Pout};
    endfunction

    function automatic kind_t kind_of(input logic [4:0] op);
        case (op)
            C_JR:    return K_JR;
`ifdef CTRL_SEQ_JAL_EN
            C_JAL:   return K_JAL;
`endif
            C_BR:    return K_BR;
            C_NOP:   return K_NOP;
            C_HALT:  return K_HALT;
            default: return K_ILL;
        endcase
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting from the cycle before T0; waits = T1 stall cycles.
    task automatic exec(input logic [31:0] iv, input logic cf, input int waits);
        logic [23:0] exp_q[$];
        bit          mr_q[$];
        kind_t       k;
        int          last;
        k = kind_of(iv[31:27]);
        exp_q.push_back(ow(S_POUT | S_MAREN | S_ZLOEN, A_INC, 1'b1, 1'b0));
        mr_q.push_back(1'($urandom));
        for (int j = 0; j <= waits; j++) begin
            exp_q.push_back(ow(S_READ | S_MDREN | ((j == 0) ? (S_ZLOOUT | S_PEN) : 17'h0),
                               5'b0, 1'b1, 1'b0));
            mr_q.push_back(j == waits);
        end
        exp_q.push_back(ow(S_MDROUT | S_IREN, 5'b0, 1'b1, 1'b0));
        mr_q.push_back(1'($urandom));
        case (k)
            K_JR:   exp_q.push_back(ow(S_GRA | S_ROUT | S_BAOUT | S_PEN, 5'b0, 1'b1, 1'b0));
            K_JAL: begin
                exp_q.push_back(ow(S_GRA | S_ROUT | S_YEN, 5'b0, 1'b1, 1'b0));
                exp_q.push_back(ow(S_POUT | S_R15EN, 5'b0, 1'b1, 1'b0));
                exp_q.push_back(ow(S_YOUT | S_PEN, 5'b0, 1'b1, 1'b0));
            end
            K_BR: begin
                exp_q.push_back(ow(S_GRA | S_ROUT | S_CONIN, 5'b0, 1'b1, 1'b0));
                exp_q.push_back(ow(S_POUT | S_YEN, 5'b0, 1'b1, 1'b0));
                exp_q.push_back(ow(S_COUT | S_ZLOEN, A_ADD, 1'b1, 1'b0));
                exp_q.push_back(ow(S_ZLOOUT | (cf ? S_PEN : 17'h0), 5'b0, 1'b1, 1'b0));
            end
            K_ILL:  exp_q.push_back(ow(17'h0, 5'b0, 1'b1, 1'b1));
            default: exp_q.push_back(ow(17'h0, 5'b0, 1'b1, 1'b0));
        endcase
        while (mr_q.size() < exp_q.size()) mr_q.push_back(1'($urandom));
        last = exp_q.size() - 1;
        for (int i = 0; i <= last; i++) begin
            step();
            check($sformatf("op%b cycle%0d", iv[31:27], i), observed(), exp_q[i]);
            check($sformatf("op%b count%0d", iv[31:27], i), {8'b0, instr_count}, {8'b0, model_count});
            if (i == 0) begin
                ir     = iv;
                con_ff = cf;
            end
            mem_ready = mr_q[i];
            start     = 1'($urandom);
            if (i == last) model_count = model_count + 16'd1;
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr         = 1'b0;
        model_count = 16'd0;
        check("clr outputs", observed(), 24'h0);
        check("clr count", {8'b0, instr_count}, 24'h0);
    endtask

    initial begin
        logic [4:0] op;
        clr         = 1'b1;
        start       = 1'b0;
        mem_ready   = 1'b0;
        ir          = 32'h0;
        con_ff      = 1'b0;
        model_count = 16'd0;
        step();
        step();
        check("reset outputs", observed(), 24'h0);
        check("reset count", {8'b0, instr_count}, 24'h0);
        clr = 1'b0;
        step();
        check("idle holds", observed(), 24'h0);

        // Directed: fetch + jr, branch taken/not taken, jal, undefined opcode.
        start = 1'b1;
        exec(32'h98800000, 1'b0, 0);
        exec(32'h90000000, 1'b1, 0);
        exec(32'h90000000, 1'b0, 1);
        exec({C_JAL, 27'h123456}, 1'b0, 0);
        exec({5'b00000, 27'h0}, 1'b0, 2);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0:       op = C_JR;
                1:       op = C_BR;
                2:       op = C_NOP;
                3:       op = C_JAL;
                default: begin
                    op = 5'($urandom_range(0, 31));
                    if (op == C_HALT) op = 5'b00001;
                end
            endcase
            exec({op, 27'($urandom)}, 1'($urandom), $urandom_range(0, 3));
        end

        // halt: parked with run low, start ignored, only clr leaves.
        exec({C_HALT, 27'h0}, 1'b0, 0);
        for (int n = 0; n < 3; n++) begin
            start = 1'b1;
            step();
            check("halt outputs", observed(), 24'h0);
            check("halt count", {8'b0, instr_count}, {8'b0, model_count});
        end
        do_clr();
        start = 1'b0;
        step();
        check("idle after halt clr", observed(), 24'h0);

        // clr during a T1 stall, with start and mem_ready also high at that edge.
        start = 1'b1;
        step();
        check("stall T0", observed(), ow(S_POUT | S_MAREN | S_ZLOEN, A_INC, 1'b1, 1'b0));
        ir        = {C_NOP, 27'h0};
        start     = 1'b0;
        mem_ready = 1'b0;
        step();
        check("stall T1 first", observed(), ow(S_READ | S_MDREN | S_ZLOOUT | S_PEN, 5'b0, 1'b1, 1'b0));
        step();
        check("stall T1 wait", observed(), ow(S_READ | S_MDREN, 5'b0, 1'b1, 1'b0));
        start     = 1'b1;
        mem_ready = 1'b1;
        do_clr();
        start     = 1'b0;
        mem_ready = 1'b0;
        step();
        check("idle after stall clr", observed(), 24'h0);

        // Counter wrap from a preloaded value.
        dut.count_q = 16'hFFFE;
        model_count = 16'hFFFE;
        #1;
        check("preload count", {8'b0, instr_count}, 24'h00FFFE);
        start = 1'b1;
        exec({C_NOP, 27'h0}, 1'b0, 0);
        exec({C_NOP, 27'h0}, 1'b0, 0);
        step();
        check("wrap count", {8'b0, instr_count}, {8'b0, model_count});
        check("wrap zero", {8'b0, instr_count}, 24'h0);
        do_clr();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
